// File: rtl/scb_issue_sched.sv
// Scoreboard issue scheduler: per-pipe round-robin grant and cell allocation,
// writeback release with a registered wakeup of the freed destination preg.
module scb_issue_sched #(
    parameter int N_RSV   = 4,
    parameter int N_PIP   = 4,
    parameter int BL_PIP  = 2,
    parameter int N_UNIT  = 4,
    parameter int BL_UNIT = 2,
    parameter int BL_PREG = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_RSV-1:0]           rsv_req,
    input  logic [N_RSV*BL_PIP-1:0]    rsv_pip,
    input  logic [N_RSV*BL_PREG-1:0]   rsv_preg,
    output logic [N_RSV-1:0]           rsv_grant,
    output logic [N_RSV*BL_UNIT-1:0]   rsv_index,
    input  logic                       wb_valid,
    input  logic [BL_PIP-1:0]          wb_pip,
    input  logic [BL_UNIT-1:0]         wb_index,
    input  logic                       flush,
    output logic                       wake_valid,
    output logic [BL_PREG-1:0]         wake_preg,
    output logic [N_PIP-1:0]           pip_full,
    output logic                       wb_err
);

    localparam int BL_RSV = (N_RSV > 1) ? $clog2(N_RSV) : 1;

    logic [N_PIP-1:0][N_UNIT-1:0] cell_valid;
    logic [N_PIP-1:0][N_UNIT-1:0] valid_nxt;
    logic [BL_PREG-1:0]           cell_preg [N_PIP][N_UNIT];
    logic [BL_RSV-1:0]            rr_ptr [N_PIP];

    logic [BL_RSV-1:0]  win [N_PIP];
    logic [BL_UNIT-1:0] free_idx [N_PIP];
    logic [BL_PREG-1:0] alloc_preg [N_PIP];
    logic [N_PIP-1:0]   pip_grant;

    logic               wb_hit;
    logic               wb_miss;
    logic [BL_PREG-1:0] wb_preg;

    // Two passes give "first candidate at or after rr_ptr, wrapping".
    always_comb begin
        logic               w_found;
        logic               f_found;
        logic [BL_RSV-1:0]  w;
        logic [BL_UNIT-1:0] f;
        logic [BL_PREG-1:0] pr;
        for (int p = 0; p < N_PIP; p++) begin
            w_found = 1'b0;
            f_found = 1'b0;
            w       = '0;
            f       = '0;
            pr      = '0;
            for (int r = 0; r < N_RSV; r++) begin
                if (!w_found && rsv_req[r]
                    && rsv_pip[r*BL_PIP +: BL_PIP] == BL_PIP'(p)
                    && BL_RSV'(r) >= rr_ptr[p]) begin
                    w_found = 1'b1;
                    w       = BL_RSV'(r);
                end
            end
            for (int r = 0; r < N_RSV; r++) begin
                if (!w_found && rsv_req[r]
                    && rsv_pip[r*BL_PIP +: BL_PIP] == BL_PIP'(p)) begin
                    w_found = 1'b1;
                    w       = BL_RSV'(r);
                end
            end
            for (int u = 0; u < N_UNIT; u++) begin
                if (!f_found && !cell_valid[p][u]) begin
                    f_found = 1'b1;
                    f       = BL_UNIT'(u);
                end
            end
            for (int r = 0; r < N_RSV; r++) begin
                if (w == BL_RSV'(r)) begin
                    pr = rsv_preg[r*BL_PREG +: BL_PREG];
                end
            end
            win[p]        = w;
            free_idx[p]   = f;
            alloc_preg[p] = pr;
            pip_grant[p]  = w_found && f_found && !flush && !rst;
        end
    end

    always_comb begin
        rsv_grant = '0;
        rsv_index = '0;
        for (int p = 0; p < N_PIP; p++) begin
            for (int r = 0; r < N_RSV; r++) begin
                if (pip_grant[p] && win[p] == BL_RSV'(r)) begin
                    rsv_grant[r] = 1'b1;
                    rsv_index[r*BL_UNIT +: BL_UNIT] = free_idx[p];
                end
            end
        end
    end

    // Release before allocate; allocation only ever picks an already-free cell.
    always_comb begin
        wb_hit    = 1'b0;
        wb_miss   = 1'b0;
        wb_preg   = '0;
        valid_nxt = cell_valid;
        for (int p = 0; p < N_PIP; p++) begin
            for (int u = 0; u < N_UNIT; u++) begin
                if (wb_valid && wb_pip == BL_PIP'(p)
                    && wb_index == BL_UNIT'(u)) begin
                    if (cell_valid[p][u]) begin
                        wb_hit          = 1'b1;
                        wb_preg         = cell_preg[p][u];
                        valid_nxt[p][u] = 1'b0;
                    end else begin
                        wb_miss = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < N_PIP; p++) begin
            for (int u = 0; u < N_UNIT; u++) begin
                if (pip_grant[p] && free_idx[p] == BL_UNIT'(u)) begin
                    valid_nxt[p][u] = 1'b1;
                end
            end
        end
        if (flush) begin
            valid_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_valid <= '0;
            wake_valid <= 1'b0;
            wake_preg  <= '0;
            pip_full   <= '0;
            wb_err     <= 1'b0;
            for (int p = 0; p < N_PIP; p++) begin
                rr_ptr[p] <= '0;
            end
        end else begin
            cell_valid <= valid_nxt;
            wake_valid <= wb_hit && !flush;
            if (wb_hit && !flush) begin
                wake_preg <= wb_preg;
            end
            if (wb_miss) begin
                wb_err <= 1'b1;
            end
            for (int p = 0; p < N_PIP; p++) begin
                pip_full[p] <= &valid_nxt[p];
                if (pip_grant[p]) begin
                    rr_ptr[p] <= (win[p] == BL_RSV'(N_RSV - 1))
                                 ? '0 : win[p] + 1'b1;
                end
            end
        end
    end

    // preg is only meaningful while its cell is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_PIP; p++) begin
            for (int u = 0; u < N_UNIT; u++) begin
                if (pip_grant[p] && free_idx[p] == BL_UNIT'(u)) begin
                    cell_preg[p][u] <= alloc_preg[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_scb_issue_sched.sv
// Bench for scb_issue_sched: directed scenarios plus random traffic,
// all checked against an array-based reference model of the cell table.
module tb_scb_issue_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  rsv_req;
    logic [7:0]  rsv_pip;
    logic [23:0] rsv_preg;
    logic [3:0]  rsv_grant;
    logic [7:0]  rsv_index;
    logic        wb_valid;
    logic [1:0]  wb_pip;
    logic [1:0]  wb_index;
    logic        flush;
    logic        wake_valid;
    logic [5:0]  wake_preg;
    logic [3:0]  pip_full;
    logic        wb_err;

    scb_issue_sched dut (
        .clk        (clk),
        .rst        (rst),
        .rsv_req    (rsv_req),
        .rsv_pip    (rsv_pip),
        .rsv_preg   (rsv_preg),
        .rsv_grant  (rsv_grant),
        .rsv_index  (rsv_index),
        .wb_valid   (wb_valid),
        .wb_pip     (wb_pip),
        .wb_index   (wb_index),
        .flush      (flush),
        .wake_valid (wake_valid),
        .wake_preg  (wake_preg),
        .pip_full   (pip_full),
        .wb_err     (wb_err)
    );

    int vecs = 0;
    int errs = 0;

    bit         mv [4][4];
    logic [5:0] mp [4][4];
    int         rr [4];
    logic       m_wv;
    logic [5:0] m_wp;
    logic [3:0] m_full;
    logic       m_err;
    logic [3:0] e_grant;
    logic [7:0] e_index;
    int         e_win [4];
    int         e_free [4];

    function automatic void model_comb();
        int r;
        e_grant = '0;
        e_index = '0;
        for (int p = 0; p < 4; p++) begin
            e_win[p]  = -1;
            e_free[p] = -1;
            for (int k = 0; k < 4; k++) begin
                r = (rr[p] + k) % 4;
                if (e_win[p] < 0 && rsv_req[r] == 1'b1
                    && int'(rsv_pip[r*2 +: 2]) == p)
                    e_win[p] = r;
            end
            for (int u = 0; u < 4; u++)
                if (e_free[p] < 0 && !mv[p][u]) e_free[p] = u;
            if (e_win[p] >= 0 && e_free[p] >= 0 && !flush && !rst) begin
                e_grant[e_win[p]] = 1'b1;
                e_index[e_win[p]*2 +: 2] = 2'(e_free[p]);
            end else begin
                e_win[p] = -1;
            end
        end
    endfunction

    task automatic model_edge();
        bit         hit;
        logic [5:0] old;
        model_comb();
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                rr[p] = 0;
                for (int u = 0; u < 4; u++) begin
                    mv[p][u] = 1'b0;
                    mp[p][u] = '0;
                end
            end
            m_wv = 1'b0; m_wp = '0; m_full = '0; m_err = 1'b0;
        end else begin
            hit = wb_valid && mv[wb_pip][wb_index];
            old = mp[wb_pip][wb_index];
            if (wb_valid && !mv[wb_pip][wb_index]) m_err = 1'b1;
            if (hit) mv[wb_pip][wb_index] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (e_win[p] >= 0) begin
                    mv[p][e_free[p]] = 1'b1;
                    mp[p][e_free[p]] = rsv_preg[e_win[p]*6 +: 6];
                    rr[p] = (e_win[p] + 1) % 4;
                end
            end
            if (flush)
                for (int p = 0; p < 4; p++)
                    for (int u = 0; u < 4; u++) mv[p][u] = 1'b0;
            m_wv = hit && !flush;
            if (m_wv) m_wp = old;
            for (int p = 0; p < 4; p++)
                m_full[p] = mv[p][0] && mv[p][1] && mv[p][2] && mv[p][3];
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        rsv_req = '0; rsv_pip = '0; rsv_preg = '0;
        wb_valid = 1'b0; wb_pip = '0; wb_index = '0;
    endtask

    task automatic set_req(input int r, input int p, input int pr);
        rsv_req[r] = 1'b1;
        rsv_pip[r*2 +: 2] = 2'(p);
        rsv_preg[r*6 +: 6] = 6'(pr);
    endtask

    task automatic set_wb(input int p, input int u);
        wb_valid = 1'b1; wb_pip = 2'(p); wb_index = 2'(u);
    endtask

    task automatic settle();
        #2;
        model_comb();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        clock_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        for (int r = 0; r < 4; r++) set_req(r, r, r);
        set_wb(1, 1);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0) begin
            errs++;
            $display("FAIL reset_grant got %b exp 0000", rsv_grant);
        end
        clock_edge();
        vecs++;
        if ({wake_valid, wake_preg, pip_full, wb_err} !== 12'h0) begin
            errs++;
            $display("FAIL reset_regs got %h exp 000",
                     {wake_valid, wake_preg, pip_full, wb_err});
        end
        idle();
    endtask

    task automatic test_fill_refill();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            set_req(0, 1, 10 + c);
            settle();
            vecs++;
            if (rsv_grant[0] !== (c < 4)
                || (c < 4 && rsv_index[1:0] !== 2'(c))) begin
                errs++;
                $display("FAIL fill_grant c=%0d got %b/%0d exp %0d/%0d",
                         c, rsv_grant[0], rsv_index[1:0], c < 4, c);
            end
            clock_edge();
            vecs++;
            if (pip_full[1] !== (c >= 3) || pip_full !== m_full) begin
                errs++;
                $display("FAIL fill_full c=%0d got %b exp %b",
                         c, pip_full, m_full);
            end
        end
        idle();
        set_wb(1, 2);
        settle();
        clock_edge();
        vecs++;
        if (wake_valid !== 1'b1 || wake_preg !== 6'd12) begin
            errs++;
            $display("FAIL refill_wake got %b/%0d exp 1/12",
                     wake_valid, wake_preg);
        end
        idle();
        set_req(0, 1, 20);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0001 || rsv_index[1:0] !== 2'd2) begin
            errs++;
            $display("FAIL refill_grant got %b/%0d exp 0001/2",
                     rsv_grant, rsv_index[1:0]);
        end
        clock_edge();
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 3, 0, 1, 3};
        int prev;
        do_reset();
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            idle();
            set_req(0, 0, 40 + c);
            set_req(1, 0, 41 + c);
            set_req(3, 0, 43 + c);
            if (prev >= 0) set_wb(0, prev);
            settle();
            vecs++;
            if (rsv_grant !== (4'b0001 << order[c])
                || rsv_index !== e_index) begin
                errs++;
                $display("FAIL rr_grant c=%0d got %b/%h exp %b/%h", c,
                         rsv_grant, rsv_index, 4'b0001 << order[c], e_index);
            end
            prev = e_free[0];
            clock_edge();
            vecs++;
            if ({wake_valid, wake_preg, pip_full, wb_err}
                !== {m_wv, m_wp, m_full, m_err}) begin
                errs++;
                $display("FAIL rr_regs c=%0d got %h exp %h", c,
                         {wake_valid, wake_preg, pip_full, wb_err},
                         {m_wv, m_wp, m_full, m_err});
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        set_req(0, 0, 5);
        set_req(2, 3, 6);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0101 || rsv_index !== 8'h00) begin
            errs++;
            $display("FAIL parallel got %b/%h exp 0101/00",
                     rsv_grant, rsv_index);
        end
        clock_edge();
    endtask

    task automatic test_wb_alloc();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            set_req(1, 2, 20 + c);
            settle();
            clock_edge();
        end
        idle();
        set_req(1, 2, 23);
        set_wb(2, 0);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0010 || rsv_index[3:2] !== 2'd3) begin
            errs++;
            $display("FAIL wb_alloc_grant got %b/%0d exp 0010/3",
                     rsv_grant, rsv_index[3:2]);
        end
        clock_edge();
        vecs++;
        if (wake_valid !== 1'b1 || wake_preg !== 6'd20
            || pip_full[2] !== 1'b0) begin
            errs++;
            $display("FAIL wb_alloc_regs got %b/%0d/%b exp 1/20/0",
                     wake_valid, wake_preg, pip_full[2]);
        end
        idle();
        set_req(1, 2, 24);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0010 || rsv_index[3:2] !== 2'd0) begin
            errs++;
            $display("FAIL wb_alloc_reuse got %b/%0d exp 0010/0",
                     rsv_grant, rsv_index[3:2]);
        end
        clock_edge();
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            set_req(0, 0, 30 + c);
            settle();
            clock_edge();
        end
        idle();
        flush = 1'b1;
        set_req(0, 0, 33);
        set_req(1, 0, 34);
        set_wb(0, 1);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0000) begin
            errs++;
            $display("FAIL flush_grant got %b exp 0000", rsv_grant);
        end
        clock_edge();
        vecs++;
        if (pip_full !== 4'b0 || wake_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_regs got %b/%b exp 0000/0",
                     pip_full, wake_valid);
        end
        idle();
        set_req(0, 0, 35);
        set_req(1, 0, 36);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0010 || rsv_index[3:2] !== 2'd0) begin
            errs++;
            $display("FAIL flush_rr got %b/%0d exp 0010/0",
                     rsv_grant, rsv_index[3:2]);
        end
        clock_edge();
    endtask

    task automatic test_wb_err_reset();
        do_reset();
        set_wb(1, 3);
        settle();
        clock_edge();
        vecs++;
        if (wb_err !== 1'b1 || wake_valid !== 1'b0) begin
            errs++;
            $display("FAIL wb_err got %b/%b exp 1/0", wb_err, wake_valid);
        end
        idle();
        for (int c = 0; c < 2; c++) begin
            set_req(c, 1, c);
            settle();
            clock_edge();
        end
        vecs++;
        if (wb_err !== 1'b1) begin
            errs++;
            $display("FAIL wb_err_sticky got %b exp 1", wb_err);
        end
        idle();
        set_wb(1, 0);
        settle();
        clock_edge();
        idle();
        rst = 1'b1;
        flush = 1'b1;
        set_req(2, 1, 9);
        set_wb(1, 1);
        settle();
        vecs++;
        if (rsv_grant !== 4'b0) begin
            errs++;
            $display("FAIL rst_grant got %b exp 0000", rsv_grant);
        end
        clock_edge();
        vecs++;
        if ({wake_valid, wake_preg, pip_full, wb_err} !== 12'h0) begin
            errs++;
            $display("FAIL rst_regs got %h exp 000",
                     {wake_valid, wake_preg, pip_full, wb_err});
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            rsv_req  = 4'($urandom);
            rsv_pip  = 8'($urandom);
            rsv_preg = 24'($urandom);
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_pip   = 2'($urandom);
            wb_index = 2'($urandom);
            settle();
            vecs++;
            if ({rsv_grant, rsv_index} !== {e_grant, e_index}) begin
                errs++;
                $display("FAIL rand_grant c=%0d got %b/%h exp %b/%h", c,
                         rsv_grant, rsv_index, e_grant, e_index);
            end
            clock_edge();
            vecs++;
            if ({wake_valid, wake_preg, pip_full, wb_err}
                !== {m_wv, m_wp, m_full, m_err}) begin
                errs++;
                $display("FAIL rand_regs c=%0d got %h exp %h", c,
                         {wake_valid, wake_preg, pip_full, wb_err},
                         {m_wv, m_wp, m_full, m_err});
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        test_reset();
        test_fill_refill();
        test_round_robin();
        test_parallel();
        test_wb_alloc();
        test_flush();
        test_wb_err_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/scb_issue_sched.md
Name: scb_issue_sched

Overview:
Issue scheduler for the stable-pipe scoreboard. It shares the scoreboard cell table between several reservation-station requesters. Per execution pipe, it round-robin arbitrates the requests and allocates a free scoreboard cell (pipe_id, unit index, destination preg) to the winner. It releases cells on pipe writeback and broadcasts a registered wakeup for the freed destination preg. Flush clears all in-flight tracking.

Parameters:
N_RSV, 4, number of reservation-station requesters
N_PIP, 4, number of stable execution pipes
BL_PIP, 2, pipe id width (clog2 N_PIP)
N_UNIT, 4, scoreboard cells (in-flight slots) per pipe
BL_UNIT, 2, unit index width (clog2 N_UNIT)
BL_PREG, 6, physical register id width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rsv_req  in  N_RSV  request to issue, one per requester
rsv_pip  in  N_RSV*BL_PIP  target pipe per requester (slice r = requester r)
rsv_preg  in  N_RSV*BL_PREG  destination preg per requester
rsv_grant  out  N_RSV  combinational grant; the requester issues this cycle
rsv_index  out  N_RSV*BL_UNIT  allocated unit index per granted requester
wb_valid  in  1  pipe writeback, releases one cell
wb_pip  in  BL_PIP  writeback pipe
wb_index  in  BL_UNIT  writeback unit index
flush  in  1  pipeline flush
wake_valid  out  1  registered wakeup strobe
wake_preg  out  BL_PREG  preg of the released cell
pip_full  out  N_PIP  registered; every cell of pipe p is valid
wb_err  out  1  sticky; writeback hit an invalid cell

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - All cell valid = 0; all round-robin pointers = 0.
  - wake_valid = 0, wake_preg = 0, pip_full = 0, wb_err = 0.
  - rsv_grant = 0 while rst is high.
- Cell table: N_PIP*N_UNIT cells {valid, preg}. Cell address = pipe*N_UNIT + index.
- Arbitration, per pipe p, in the same cycle:
  - Candidates: requesters with rsv_req=1 and rsv_pip=p.
  - Winner: the first candidate at or after rr_ptr[p], wrapping modulo N_RSV.
  - The winner is granted only if pipe p has a free cell in the registered state, and flush=0 and rst=0.
  - At most one grant per pipe per cycle. Requesters targeting different pipes may be granted in the same cycle.
- Allocation:
  - Granted cell = lowest-index free cell of pipe p, driven on rsv_index.
  - On the clock edge: cell.valid <= 1, cell.preg <= rsv_preg; rr_ptr[p] <= winner+1 mod N_RSV.
  - rr_ptr[p] is unchanged when pipe p has no grant.
- Grant latency: rsv_grant is combinational. The new cell is visible, and counts toward pip_full, from the next cycle.
- No free-slot bypass: a cell released by wb this cycle cannot be allocated until the next cycle.
- Writeback:
  - On wb_valid with a valid target cell: clear valid at the edge; next cycle wake_valid=1 and wake_preg = that cell's preg.
  - Otherwise wake_valid=0 next cycle, and wake_preg holds its last value.
- Invalid writeback: wb_valid to an invalid cell is ignored (no wakeup) and sets wb_err; wb_err clears only on rst.
- Same-cycle writeback and allocate on one pipe: both occur. The allocation uses a cell that was already free, so it never selects the cell being released.
- pip_full[p] is registered and computed from the next-state table.
- Flush, when flush=1:
  - All grants are suppressed.
  - All cells are cleared at the edge, overriding a same-cycle writeback release; no wakeup is produced for that writeback.
  - wake_valid=0 next cycle.
  - rr_ptr values are preserved.
- rst mid-operation: every state returns to its reset value at the next edge, regardless of req, wb or flush.
- Unknown pipe ids: rsv_pip or wb_pip >= N_PIP (possible when N_PIP is not a power of 2) never grants, and wb with such an id is ignored without setting wb_err.

Test Plan:
1. Fill and refill: after reset, requester 0 requests pipe 1 for 5 cycles with preg 10..14.
   - Grants on cycles 0-3 with index 0,1,2,3; pip_full[1]=1 from cycle 4; no grant on cycle 4.
   - wb (pip 1, index 2) -> next cycle wake_preg=12; following cycle requester 0 is granted index 2.
2. Round robin: requesters 0, 1 and 3 all request pipe 0 every cycle, with frees available.
   - Grant order 0,1,3,0,1,3; exactly one grant per cycle.
3. Parallel pipes: requester 0 targets pipe 0 and requester 2 targets pipe 3 in the same cycle -> both granted, both index 0.
4. Same-cycle writeback and allocate: pipe 2 holds indices 0-2 valid; in one cycle wb (2, 0) and requester 1 requests pipe 2.
   - Grant at index 3; next cycle index 0 is free, wake_valid=1, pip_full[2]=0.
5. Flush: 3 cells valid, and in one cycle flush=1 with a request and a wb.
   - rsv_grant=0; next cycle all cells invalid, pip_full=0, wake_valid=0.
   - Round-robin pointer unchanged: the next grant goes to the expected requester.
6. Writeback error and reset: wb to an empty cell -> wb_err=1, no wakeup; wb_err stays 1 until rst=1, and all outputs are 0 the cycle after rst.
